// File: rtl/temp_register_ctrl.sv
// Command sequencer for an 8-bit signed temp register: issues load/inc/dec strobes
// and runs a RAMP toward zero under a step limit, reporting done/timeout/illegal.
module temp_register_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              flag_negative,
  input  logic              flag_positive,
  input  logic              flag_zero,
  output logic              reg_load,
  output logic              reg_inc,
  output logic              reg_dec,
  output logic [DATA_W-1:0] reg_data,
  output logic              done,
  output logic              timeout,
  output logic              illegal,
  output logic [DATA_W-1:0] step_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_RAMP = 3'b100;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   step_q, step_d;
  logic                dir_inc_q, dir_inc_d;
  logic                timeout_q, timeout_d;
  logic                illegal_q, illegal_d;
  logic                ready_q, ready_d;
  logic                load_q, load_d;
  logic                inc_q, inc_d;
  logic                dec_q, dec_d;
  logic                done_q, done_d;
  logic                accept_s;

  assign accept_s = instr_valid & ready_q;

  // State register and registered outputs; reset aborts any operation without a done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 3'b000;
      imm_q     <= '0;
      data_q    <= '0;
      step_q    <= '0;
      dir_inc_q <= 1'b0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b1;
      load_q    <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      data_q    <= data_d;
      step_q    <= step_d;
      dir_inc_q <= dir_inc_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
      load_q    <= load_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    imm_d     = imm_q;
    data_d    = data_q;
    step_d    = step_q;
    dir_inc_d = dir_inc_q;
    timeout_d = timeout_q;
    illegal_d = illegal_q;
    load_d    = 1'b0;
    inc_d     = 1'b0;
    dec_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d      = instr_op;
          imm_d     = instr_imm;
          data_d    = instr_imm;
          step_d    = '0;
          timeout_d = 1'b0;
          illegal_d = 1'b0;
          case (instr_op)
            OP_NOP:  state_d = S_DONE;
            OP_LOAD: state_d = S_ISSUE;
            OP_INC:  state_d = S_ISSUE;
            OP_DEC:  state_d = S_ISSUE;
            OP_RAMP: state_d = S_CHECK;
            default: begin
              state_d   = S_DONE;
              illegal_d = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (op_q == OP_RAMP) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_DONE;
        end
      end
      S_CHECK: begin
        // Flags already reflect the strobe issued in the previous cycle
        if (flag_zero) begin
          state_d = S_DONE;
        end else if (step_q == imm_q) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (flag_negative) begin
          state_d   = S_ISSUE;
          dir_inc_d = 1'b1;
        end else if (flag_positive) begin
          state_d   = S_ISSUE;
          dir_inc_d = 1'b0;
        end else begin
          state_d   = S_DONE;
          illegal_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_ISSUE) begin
      case (op_d)
        OP_LOAD: load_d = 1'b1;
        OP_INC:  inc_d  = 1'b1;
        OP_DEC:  dec_d  = 1'b1;
        OP_RAMP: begin
          inc_d  = dir_inc_d;
          dec_d  = ~dir_inc_d;
          step_d = step_q + DATA_W'(1);
        end
        default: begin
          load_d = 1'b0;
        end
      endcase
    end else begin
      load_d = 1'b0;
    end

    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  assign instr_ready = ready_q;
  assign reg_load    = load_q;
  assign reg_inc     = inc_q;
  assign reg_dec     = dec_q;
  assign reg_data    = data_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign illegal     = illegal_q;
  assign step_count  = step_q;

endmodule

// File: tb/tb_temp_register_ctrl.sv
// Directed bench for temp_register_ctrl with a behavioural signed temp register
// supplying the flags.
module tb_temp_register_ctrl;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [DATA_W-1:0] instr_imm;
  logic              flag_negative, flag_positive, flag_zero;
  logic              reg_load, reg_inc, reg_dec;
  logic [DATA_W-1:0] reg_data;
  logic              done, timeout, illegal;
  logic [DATA_W-1:0] step_count;

  logic signed [7:0] treg;
  logic              noflag;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cyc, n_load, n_inc, n_dec, overlap;
  logic [31:0] str_mask;
  logic        to_s, ill_s, zero_s;
  logic [7:0]  sc_s;
  logic        seen;
  int          n_done;

  always #5 clk = ~clk;

  temp_register_ctrl #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm),
    .flag_negative(flag_negative), .flag_positive(flag_positive), .flag_zero(flag_zero),
    .reg_load(reg_load), .reg_inc(reg_inc), .reg_dec(reg_dec), .reg_data(reg_data),
    .done(done), .timeout(timeout), .illegal(illegal), .step_count(step_count)
  );

  // Behavioural temp register driven by the controller strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) treg <= 8'sd0;
    else if (reg_load) treg <= reg_data;
    else if (reg_inc) treg <= treg + 8'sd1;
    else if (reg_dec) treg <= treg - 8'sd1;
  end

  assign flag_zero     = !noflag && (treg == 8'sd0);
  assign flag_negative = !noflag && treg[7];
  assign flag_positive = !noflag && !treg[7] && (treg != 8'sd0);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction and observe cycles 1..budget relative to the accept cycle
  task automatic run_instr(input logic [2:0] op, input logic [7:0] imm, input int budget);
    @(negedge clk);
    check_val("ready_idle", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr_op    = op;
    instr_imm   = imm;
    @(negedge clk);
    instr_valid = 1'b0;
    check_val("ready_busy", 32'(instr_ready), 32'd0);
    done_cyc = -1; n_load = 0; n_inc = 0; n_dec = 0; overlap = 0; str_mask = 32'd0;
    to_s = 1'b0; ill_s = 1'b0; sc_s = 8'd0; zero_s = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) @(negedge clk);
      n_load += 32'(reg_load);
      n_inc  += 32'(reg_inc);
      n_dec  += 32'(reg_dec);
      if (32'(reg_load) + 32'(reg_inc) + 32'(reg_dec) > 1) overlap++;
      if (k < 32 && (reg_load || reg_inc || reg_dec)) str_mask[k] = 1'b1;
      if (done) begin
        done_cyc = k;
        to_s = timeout; ill_s = illegal; sc_s = step_count; zero_s = flag_zero;
        break;
      end
    end
    check_val("strobe_overlap", 32'(overlap), 32'd0);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr_op = 3'b000; instr_imm = 8'h00; noflag = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_ready", 32'(instr_ready), 32'd1);
    check_val("rst_strobes", {29'd0, reg_load, reg_inc, reg_dec}, 32'd0);
    check_val("rst_flags_out", {29'd0, done, timeout, illegal}, 32'd0);
    check_val("rst_step", 32'(step_count), 32'd0);
    check_val("rst_data", 32'(reg_data), 32'd0);
    reset = 1'b0;

    // LOAD 0x85
    run_instr(3'b001, 8'h85, 10);
    check_val("load_done_cyc", 32'(done_cyc), 32'd2);
    check_val("load_mask", str_mask, 32'h2);
    check_val("load_count", 32'(n_load), 32'd1);
    check_val("load_incdec", 32'(n_inc + n_dec), 32'd0);
    check_val("load_data", 32'(reg_data), 32'h85);
    check_val("load_neg_flag", 32'(flag_negative), 32'd1);
    @(negedge clk);
    check_val("load_ready_c3", 32'(instr_ready), 32'd1);

    // Register +3, RAMP 10
    run_instr(3'b001, 8'h03, 10);
    run_instr(3'b100, 8'd10, 40);
    check_val("ramp3_done_cyc", 32'(done_cyc), 32'd8);
    check_val("ramp3_mask", str_mask, 32'h54);
    check_val("ramp3_dec", 32'(n_dec), 32'd3);
    check_val("ramp3_inc", 32'(n_inc), 32'd0);
    check_val("ramp3_step", 32'(sc_s), 32'd3);
    check_val("ramp3_timeout", 32'(to_s), 32'd0);
    check_val("ramp3_zero", 32'(zero_s), 32'd1);

    // Register -128, RAMP 255
    run_instr(3'b001, 8'h80, 10);
    run_instr(3'b100, 8'd255, 300);
    check_val("ramp128_done_cyc", 32'(done_cyc), 32'd258);
    check_val("ramp128_inc", 32'(n_inc), 32'd128);
    check_val("ramp128_dec", 32'(n_dec), 32'd0);
    check_val("ramp128_step", 32'(sc_s), 32'd128);
    check_val("ramp128_timeout", 32'(to_s), 32'd0);

    // Register +5, RAMP 2 hits the step limit
    run_instr(3'b001, 8'h05, 10);
    run_instr(3'b100, 8'd2, 40);
    check_val("ramplim_done_cyc", 32'(done_cyc), 32'd6);
    check_val("ramplim_mask", str_mask, 32'h14);
    check_val("ramplim_timeout", 32'(to_s), 32'd1);
    check_val("ramplim_step", 32'(sc_s), 32'd2);
    check_val("ramplim_reg", 32'(treg), 32'd3);

    // Reserved op then INC
    run_instr(3'b110, 8'h00, 10);
    check_val("rsv_done_cyc", 32'(done_cyc), 32'd1);
    check_val("rsv_illegal", 32'(ill_s), 32'd1);
    check_val("rsv_strobes", 32'(n_load + n_inc + n_dec), 32'd0);
    run_instr(3'b010, 8'h00, 10);
    check_val("inc_done_cyc", 32'(done_cyc), 32'd2);
    check_val("inc_illegal", 32'(ill_s), 32'd0);
    check_val("inc_count", 32'(n_inc), 32'd1);
    check_val("inc_mask", str_mask, 32'h2);
    check_val("inc_reg", 32'(treg), 32'd4);

    // DEC
    run_instr(3'b011, 8'h00, 10);
    check_val("dec_count", 32'(n_dec), 32'd1);
    check_val("dec_reg", 32'(treg), 32'd3);

    // RAMP imm 0 on non-zero register
    run_instr(3'b100, 8'd0, 10);
    check_val("ramp0_done_cyc", 32'(done_cyc), 32'd2);
    check_val("ramp0_timeout", 32'(to_s), 32'd1);
    check_val("ramp0_step", 32'(sc_s), 32'd0);
    check_val("ramp0_strobes", 32'(n_inc + n_dec), 32'd0);

    // NOP clears held status
    run_instr(3'b000, 8'h00, 10);
    check_val("nop_done_cyc", 32'(done_cyc), 32'd1);
    check_val("nop_status", {30'd0, to_s, ill_s}, 32'd0);

    // RAMP with no flag asserted
    noflag = 1'b1;
    run_instr(3'b100, 8'd5, 10);
    noflag = 1'b0;
    check_val("noflag_done_cyc", 32'(done_cyc), 32'd2);
    check_val("noflag_illegal", 32'(ill_s), 32'd1);
    check_val("noflag_strobes", 32'(n_inc + n_dec), 32'd0);

    // Register already zero: RAMP finishes in cycle 2
    run_instr(3'b001, 8'h00, 10);
    run_instr(3'b100, 8'd7, 10);
    check_val("rampz_done_cyc", 32'(done_cyc), 32'd2);
    check_val("rampz_status", {30'd0, to_s, ill_s}, 32'd0);

    // Reset during a RAMP ISSUE cycle
    run_instr(3'b001, 8'h0A, 10);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 3'b100; instr_imm = 8'd50;
    @(negedge clk);
    instr_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (reg_dec) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("midrst_dec_seen", 32'(seen), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_val("midrst_strobes", {29'd0, reg_load, reg_inc, reg_dec}, 32'd0);
    check_val("midrst_ready", 32'(instr_ready), 32'd1);
    check_val("midrst_step", 32'(step_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_done += 32'(done);
    end
    check_val("midrst_no_done", 32'(n_done), 32'd0);
    check_val("midrst_ready_after", 32'(instr_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/temp_register_ctrl.md
Name: temp_register_ctrl

Overview:
- Command sequencer that drives the 8-bit signed temp register's load/increment/decrement/data controls and consumes its negative/positive/zero flags.
- Accepts one instruction at a time over a valid/ready handshake and issues single-cycle control strobes.
- Runs a multi-cycle RAMP instruction that walks the register toward zero, with a step limit.
- Reports completion, step count and status to the application-specific processor's top-level control.

Parameters:
- DATA_W, 8, width of register data, immediate and step counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction present.
- instr_ready  output  1  controller can accept; high only in IDLE.
- instr_op  input  3  000 NOP, 001 LOAD, 010 INC, 011 DEC, 100 RAMP, 101-111 reserved.
- instr_imm  input  DATA_W  LOAD value, or RAMP step limit.
- flag_negative  input  1  register flag.
- flag_positive  input  1  register flag.
- flag_zero  input  1  register flag.
- reg_load  output  1  register load strobe.
- reg_inc  output  1  register increment strobe.
- reg_dec  output  1  register decrement strobe.
- reg_data  output  DATA_W  load data; holds latched imm.
- done  output  1  one-cycle completion pulse.
- timeout  output  1  RAMP hit its step limit; valid with done, held until next accept.
- illegal  output  1  reserved op, or no flag asserted in CHECK; held until next accept.
- step_count  output  DATA_W  strobes issued by the current or last RAMP.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values:
  - State = IDLE, instr_ready = 1.
  - All strobes, done, timeout and illegal = 0.
  - step_count = 0, reg_data = 0, latched op/imm = 0.
- Reset mid-operation aborts immediately. Strobes deassert asynchronously and no done pulse is issued.
- All outputs are registered. At most one of reg_load/reg_inc/reg_dec is high in any cycle, for exactly one cycle.
- States: IDLE, ISSUE, CHECK, DONE.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready, latch op and imm, clear timeout, illegal and step_count.
  - NOP or reserved op -> DONE. Reserved op also sets illegal.
  - LOAD/INC/DEC -> ISSUE.
  - RAMP -> CHECK.
  - instr_valid without ready is ignored; the source holds it.
- ISSUE: assert the strobe for the latched op for one cycle.
  - LOAD drives reg_load with reg_data = imm.
  - RAMP drives reg_inc or reg_dec as decided in CHECK, and step_count increments.
  - Next state: DONE for LOAD/INC/DEC, CHECK for RAMP.
- CHECK: sample flags, which reflect any strobe issued in the preceding cycle. Priority is zero > negative > positive.
  - zero -> DONE.
  - else step_count == imm -> DONE with timeout = 1.
  - else negative -> ISSUE (increment).
  - else positive -> ISSUE (decrement).
  - else (no flag asserted) -> DONE with illegal = 1.
- DONE: done = 1 for one cycle -> IDLE. instr_ready rises the cycle after done.
- Latency from the accept cycle (cycle 0):
  - NOP: done in cycle 1.
  - LOAD/INC/DEC: strobe in cycle 1, done in cycle 2.
  - RAMP over N steps: done in cycle 2N+2. N = 0 (already zero) gives done in cycle 2.
- Arithmetic:
  - Controller never computes register values; two's-complement wrap (127+1 = -128) is the register's concern.
  - step_count is unsigned and never wraps, because imm <= 2^DATA_W - 1 bounds it.
- RAMP with imm = 0 and non-zero register: DONE with timeout = 1, no strobes, step_count = 0.
- Back-to-back: the earliest next accept is the cycle after done. No instruction is accepted while busy.

Test Plan:
- Reset asserted mid-RAMP (during ISSUE) -> strobes low in the same cycle, instr_ready = 1, step_count = 0, no done after release.
- LOAD imm = 0x85 accepted in cycle 0 -> reg_load = 1 and reg_data = 0x85 in cycle 1, done in cycle 2, register flags negative; instr_ready high in cycle 3.
- Register = +3, RAMP imm = 10 -> reg_dec pulses in cycles 2, 4, 6, done in cycle 8, step_count = 3, timeout = 0, flag_zero = 1.
- Register = -128, RAMP imm = 255 -> 128 reg_inc pulses, done in cycle 258, step_count = 128, timeout = 0.
- Register = +5, RAMP imm = 2 -> two reg_dec pulses, done with timeout = 1, step_count = 2, register = 3.
- Op 110 -> no strobes, done in cycle 1, illegal = 1. Next accepted INC clears illegal and pulses reg_inc once.
